// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus broadcaster from FU holding regs to ROB slots.
// Define CDB_BYPASS_EN to let idle requesting FUs join arbitration in their request cycle.
module cdb_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int FU_NUM     = 6,
  parameter int STORER_NUM = 1,
  parameter int RB_SIZE    = 8,
  parameter int RB_INDEX   = 3,
  parameter int CDB_PORTS  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [FU_NUM-1:0]               fu_req,
  output logic [FU_NUM-1:0]               fu_ready,
  input  logic [WORD_SIZE*FU_NUM-1:0]     data_bus,
  input  logic [WORD_SIZE*STORER_NUM-1:0] addr_bus,
  input  logic [RB_INDEX*FU_NUM-1:0]      RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0]    CDB_data_data,
  output logic [RB_SIZE-1:0]              CDB_data_valid,
  output logic [WORD_SIZE*RB_SIZE-1:0]    CDB_data_addr,
  output logic [FU_NUM-1:0]               cdb_grant
);
  localparam int PW       = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int FIRST_ST = FU_NUM - STORER_NUM;
  localparam int SLOTS    = 1 << RB_INDEX;

  logic [WORD_SIZE-1:0] in_data [FU_NUM];
  logic [WORD_SIZE-1:0] in_addr [FU_NUM];
  logic [RB_INDEX-1:0]  in_idx  [FU_NUM];

  logic [WORD_SIZE-1:0] data_q  [FU_NUM];
  logic [WORD_SIZE-1:0] addr_q  [FU_NUM];
  logic [RB_INDEX-1:0]  idx_q   [FU_NUM];
  logic [FU_NUM-1:0]    held_q, held_d;
  logic [PW-1:0]        rr_q, rr_d;

  logic [FU_NUM-1:0]    grant_held, grant_byp, grant_all, xfer;
  logic [SLOTS-1:0]     used;
  int                   cnt;

  logic [WORD_SIZE*RB_SIZE-1:0] bc_data_q, bc_data_d;
  logic [WORD_SIZE*RB_SIZE-1:0] bc_addr_q, bc_addr_d;
  logic [RB_SIZE-1:0]           bc_valid_q, bc_valid_d;
  logic [FU_NUM-1:0]            grant_q;

  for (genvar g = 0; g < FU_NUM; g++) begin : g_in
    assign in_data[g] = data_bus[g*WORD_SIZE +: WORD_SIZE];
    assign in_idx[g]  = RB_index_bus[g*RB_INDEX +: RB_INDEX];
    if (g >= FIRST_ST) begin : g_st
      assign in_addr[g] = addr_bus[(g-FIRST_ST)*WORD_SIZE +: WORD_SIZE];
    end else begin : g_nst
      assign in_addr[g] = '0;
    end
  end

  // Held entries are scanned first; bypass candidates queue behind them.
  always_comb begin
    grant_held = '0;
    grant_byp  = '0;
    used       = '0;
    cnt        = 0;
    rr_d       = rr_q;
    for (int o = 0; o < FU_NUM; o++) begin
      for (int i = 0; i < FU_NUM; i++) begin
        if ((int'(rr_q) + o) % FU_NUM == i) begin
          if (held_q[i] && cnt < CDB_PORTS &&
              int'(idx_q[i]) < RB_SIZE && !used[idx_q[i]]) begin
            grant_held[i]    = 1'b1;
            used[idx_q[i]]   = 1'b1;
            cnt              = cnt + 1;
            rr_d             = PW'((i + 1) % FU_NUM);
          end
        end
      end
    end
`ifdef CDB_BYPASS_EN
    for (int o = 0; o < FU_NUM; o++) begin
      for (int i = 0; i < FU_NUM; i++) begin
        if ((int'(rr_q) + o) % FU_NUM == i) begin
          if (fu_req[i] && !held_q[i] && cnt < CDB_PORTS &&
              int'(in_idx[i]) < RB_SIZE && !used[in_idx[i]]) begin
            grant_byp[i]     = 1'b1;
            used[in_idx[i]]  = 1'b1;
            cnt              = cnt + 1;
            rr_d             = PW'((i + 1) % FU_NUM);
          end
        end
      end
    end
`endif
  end

  assign grant_all = grant_held | grant_byp;
  assign fu_ready  = ~held_q | grant_held;
  assign xfer      = fu_req & fu_ready;

  always_comb begin
    held_d = held_q;
    for (int i = 0; i < FU_NUM; i++) begin
      if (xfer[i]) held_d[i] = ~grant_byp[i];
      else if (grant_held[i]) held_d[i] = 1'b0;
    end
  end

  always_comb begin
    bc_data_d  = '0;
    bc_addr_d  = '0;
    bc_valid_d = '0;
    for (int k = 0; k < RB_SIZE; k++) begin
      for (int i = 0; i < FU_NUM; i++) begin
        if (grant_held[i] && int'(idx_q[i]) == k) begin
          bc_valid_d[k] = 1'b1;
          bc_data_d[k*WORD_SIZE +: WORD_SIZE] = data_q[i];
          bc_addr_d[k*WORD_SIZE +: WORD_SIZE] = addr_q[i];
        end
        if (grant_byp[i] && int'(in_idx[i]) == k) begin
          bc_valid_d[k] = 1'b1;
          bc_data_d[k*WORD_SIZE +: WORD_SIZE] = in_data[i];
          bc_addr_d[k*WORD_SIZE +: WORD_SIZE] = in_addr[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q     <= '0;
      rr_q       <= '0;
      bc_data_q  <= '0;
      bc_addr_q  <= '0;
      bc_valid_q <= '0;
      grant_q    <= '0;
      for (int i = 0; i < FU_NUM; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      held_q     <= held_d;
      rr_q       <= rr_d;
      bc_data_q  <= bc_data_d;
      bc_addr_q  <= bc_addr_d;
      bc_valid_q <= bc_valid_d;
      grant_q    <= grant_all;
      for (int i = 0; i < FU_NUM; i++) begin
        if (xfer[i]) begin
          data_q[i] <= in_data[i];
          addr_q[i] <= in_addr[i];
          idx_q[i]  <= in_idx[i];
        end
      end
    end
  end

  assign CDB_data_data  = bc_data_q;
  assign CDB_data_addr  = bc_addr_q;
  assign CDB_data_valid = bc_valid_q;
  assign cdb_grant      = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a queue-based broadcast scoreboard.
// Build with CDB_BYPASS_EN to exercise the one-cycle bypass path.
module tb_cdb_arbiter;
  localparam int W = 32;
  localparam int N = 6;
`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [7:0]   valid;
    logic [255:0] data;
    logic [255:0] addr;
    logic [5:0]   grant;
    int           cyc;
  } exp_t;

  logic         clk = 0;
  logic         reset = 0;
  logic [5:0]   fu_req = '0;
  logic [5:0]   fu_ready;
  logic [191:0] data_bus = '0;
  logic [31:0]  addr_bus = '0;
  logic [17:0]  RB_index_bus = '0;
  logic [255:0] CDB_data_data;
  logic [7:0]   CDB_data_valid;
  logic [255:0] CDB_data_addr;
  logic [5:0]   cdb_grant;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .fu_req(fu_req), .fu_ready(fu_ready),
    .data_bus(data_bus), .addr_bus(addr_bus), .RB_index_bus(RB_index_bus),
    .CDB_data_data(CDB_data_data), .CDB_data_valid(CDB_data_valid),
    .CDB_data_addr(CDB_data_addr), .cdb_grant(cdb_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic exp_t blank(input int c);
    exp_t e;
    e.valid = '0; e.data = '0; e.addr = '0; e.grant = '0; e.cyc = c;
    return e;
  endfunction

  task automatic set_fu(input int i, input logic [31:0] d, input int k);
    data_bus[i*W +: W] = d;
    RB_index_bus[i*3 +: 3] = k[2:0];
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d broadcasts outstanding, required 0",
               nm, q.size());
      q.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!reset && (CDB_data_valid != '0 || cdb_grant != '0)) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_bcast: valid=%b grant=%b, required none",
                   CDB_data_valid, cdb_grant);
        end else begin
          e = q.pop_front();
          chk("bc_cycle", cyc, e.cyc);
          chk("bc_valid", CDB_data_valid, e.valid);
          chk("bc_data", CDB_data_data, e.data);
          chk("bc_addr", CDB_data_addr, e.addr);
          chk("bc_grant", cdb_grant, e.grant);
        end
      end
    end
  end

  initial begin : stim
    exp_t e;
    int   c;
    reset = 1;
    #12 reset = 0;
    chk("rst_valid", CDB_data_valid, 8'h00);
    chk("rst_data", CDB_data_data, '0);
    chk("rst_addr", CDB_data_addr, '0);
    chk("rst_grant", cdb_grant, 6'h00);
    chk("rst_ready", fu_ready, 6'h3f);

    // T1: reset mid-broadcast while FU1 is still held behind FU0
    @(negedge clk); c = cyc;
    set_fu(0, 32'h1234, 0); set_fu(1, 32'h5678, 0); fu_req = 6'b000011;
    e = blank(c + LAT); e.valid = 8'h01; e.data[31:0] = 32'h1234;
    e.grant = 6'b000001; q.push_back(e);
    @(negedge clk); fu_req = '0;
    if (LAT == 2) begin @(posedge clk); #2; end
    reset = 1; #1;
    chk("t1_valid0", CDB_data_valid, 8'h00);
    chk("t1_data0", CDB_data_data, '0);
    chk("t1_grant0", cdb_grant, 6'h00);
    @(negedge clk); reset = 0;
    repeat (4) @(negedge clk);
    chk("t1_ready", fu_ready, 6'h3f);
    wait_drain("t1");

    // T2: single FU2 result to slot 5
    do_reset();
    @(negedge clk); c = cyc;
    set_fu(2, 32'h0000_00AA, 5); fu_req = 6'b000100;
    e = blank(c + LAT); e.valid = 8'b0010_0000; e.data[5*W +: W] = 32'hAA;
    e.grant = 6'b000100; q.push_back(e);
    @(negedge clk); fu_req = '0;
    repeat (4) @(negedge clk);
    wait_drain("t2");

    // T3: all six at once, pairs granted on consecutive cycles
    do_reset();
    @(negedge clk); c = cyc;
    for (int i = 0; i < N; i++) set_fu(i, 32'hA0 + i, i);
    fu_req = 6'h3f;
    for (int p = 0; p < 3; p++) begin
      e = blank(c + LAT + p);
      e.valid[2*p] = 1'b1; e.valid[2*p+1] = 1'b1;
      e.data[(2*p)*W +: W] = 32'hA0 + 2*p;
      e.data[(2*p+1)*W +: W] = 32'hA0 + 2*p + 1;
      e.grant[2*p] = 1'b1; e.grant[2*p+1] = 1'b1;
      q.push_back(e);
    end
    @(negedge clk); fu_req = '0;
`ifdef CDB_BYPASS_EN
    chk("t3_ready1", fu_ready, 6'b001111);
    @(negedge clk);
    chk("t3_ready2", fu_ready, 6'b111111);
`else
    chk("t3_ready1", fu_ready, 6'b000011);
    @(negedge clk);
    chk("t3_ready2", fu_ready, 6'b001111);
    @(negedge clk);
    chk("t3_ready3", fu_ready, 6'b111111);
`endif
    repeat (3) @(negedge clk);
    wait_drain("t3");

    // T4: FU0 and FU3 collide on slot 2
    do_reset();
    @(negedge clk); c = cyc;
    set_fu(0, 32'hC0, 2); set_fu(3, 32'hC3, 2); fu_req = 6'b001001;
    e = blank(c + LAT); e.valid = 8'b0000_0100; e.data[2*W +: W] = 32'hC0;
    e.grant = 6'b000001; q.push_back(e);
    e = blank(c + LAT + 1); e.valid = 8'b0000_0100; e.data[2*W +: W] = 32'hC3;
    e.grant = 6'b001000; q.push_back(e);
    @(negedge clk); fu_req = '0;
    repeat (4) @(negedge clk);
    wait_drain("t4");

    // T5: storer FU5 with address alongside non-storer FU1
    do_reset();
    @(negedge clk); c = cyc;
    set_fu(5, 32'h55, 7); addr_bus = 32'h1000;
    set_fu(1, 32'h11, 4); fu_req = 6'b100010;
    e = blank(c + LAT); e.valid = 8'b1001_0000;
    e.data[7*W +: W] = 32'h55; e.data[4*W +: W] = 32'h11;
    e.addr[7*W +: W] = 32'h1000;
    e.grant = 6'b100010; q.push_back(e);
    @(negedge clk); fu_req = '0;
    repeat (4) @(negedge clk);
    wait_drain("t5");

    // T6: FU4 alone into slot 3; one-edge latency when bypass is built in
    do_reset();
    @(negedge clk); c = cyc;
    set_fu(4, 32'h66, 3); fu_req = 6'b010000;
    e = blank(c + LAT); e.valid = 8'b0000_1000; e.data[3*W +: W] = 32'h66;
    e.grant = 6'b010000; q.push_back(e);
    @(negedge clk); fu_req = '0;
    repeat (4) @(negedge clk);
    wait_drain("t6");

    // T7: back-to-back results from FU2 reload the holding register
    do_reset();
    @(negedge clk); c = cyc;
    set_fu(2, 32'hB1, 6); fu_req = 6'b000100;
    e = blank(c + LAT); e.valid = 8'b0100_0000; e.data[6*W +: W] = 32'hB1;
    e.grant = 6'b000100; q.push_back(e);
    e = blank(c + LAT + 1); e.valid = 8'b0100_0000; e.data[6*W +: W] = 32'hB2;
    e.grant = 6'b000100; q.push_back(e);
    @(negedge clk);
    set_fu(2, 32'hB2, 6);
    @(negedge clk); fu_req = '0;
    repeat (4) @(negedge clk);
    wait_drain("t7");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
